// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter
// Description : Single-port frame-buffer RAM arbiter. Scanout reads take
//               absolute priority, a full-frame clear engine comes next, and
//               queued pixel writes fill the remaining cycles in order.
//               Out-of-range writes are dropped and flagged on wr_oob.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter #(
  parameter int FB_SIZE    = 307200,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [2:0]        disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  output logic              wr_oob,
  input  logic              clr_start,
  input  logic [2:0]        clr_color,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int                c_ptr_w     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   c_fb_size   = (ADDR_W+1)'(FB_SIZE);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_SIZE - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_drain = 2'd1;
  localparam logic [1:0] c_st_clear = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic [ADDR_W-1:0] clr_cnt_q,    clr_cnt_d;
  logic [2:0]        clr_color_q,  clr_color_d;
  logic              disp_valid_q, disp_valid_d;
  logic              wr_oob_q,     wr_oob_d;
  logic [c_ptr_w:0]  wr_ptr_q,     wr_ptr_d;
  logic [c_ptr_w:0]  rd_ptr_q,     rd_ptr_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [2:0]        fifo_data_q [FIFO_DEPTH];
  logic [2:0]        fifo_data_d [FIFO_DEPTH];

  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_pop;
  logic              w_clr_wr;
  logic [ADDR_W-1:0] w_head_addr;
  logic [2:0]        w_head_data;
  logic              w_head_oob;

  // FIFO status, head entry and the per-cycle grant decisions.
  always_comb begin
    w_fifo_empty = (wr_ptr_q == rd_ptr_q);
    w_fifo_full  = (wr_ptr_q[c_ptr_w] != rd_ptr_q[c_ptr_w]) &&
                   (wr_ptr_q[c_ptr_w-1:0] == rd_ptr_q[c_ptr_w-1:0]);
    w_head_addr  = fifo_addr_q[rd_ptr_q[c_ptr_w-1:0]];
    w_head_data  = fifo_data_q[rd_ptr_q[c_ptr_w-1:0]];
    w_head_oob   = ({1'b0, w_head_addr} >= c_fb_size);
    clr_busy     = (state_q != c_st_idle);
    // rst_n gating keeps the handshake quiet while reset is held.
    wr_ready     = rst_n && !w_fifo_full && !clr_busy;
    w_push       = wr_valid && wr_ready;
    w_pop        = rst_n && !disp_req && (state_q != c_st_clear) && !w_fifo_empty;
    w_clr_wr     = rst_n && !disp_req && (state_q == c_st_clear);
  end

  // Write-queue storage and pointer update; push and pop may coincide.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (w_push) begin
      fifo_addr_d[wr_ptr_q[c_ptr_w-1:0]] = wr_addr;
      fifo_data_d[wr_ptr_q[c_ptr_w-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Next state for the clear controller, its counter and latched colour.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    case (state_q)
      c_st_idle: begin
        if (clr_start) begin
          clr_color_d = clr_color;
          clr_cnt_d   = '0;
          state_d     = w_fifo_empty ? c_st_clear : c_st_drain;
        end
      end
      c_st_drain: begin
        // No pushes are possible here, so the queue only shrinks.
        if (w_fifo_empty) begin
          state_d   = c_st_clear;
          clr_cnt_d = '0;
        end
      end
      c_st_clear: begin
        // A scanout read stalls the sweep; the counter wraps to 0 on exit.
        if (!disp_req) begin
          if (clr_cnt_q == c_last_addr) begin
            state_d   = c_st_idle;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = c_st_idle;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Output decode: one RAM access per cycle in fixed priority order.
  always_comb begin
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    disp_valid_d = disp_req;
    wr_oob_d     = w_pop && w_head_oob;
    if (!rst_n) begin
      mem_en = 1'b0;
    end else if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (w_clr_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_cnt_q;
      mem_wdata = clr_color_q;
    end else if (w_pop && !w_head_oob) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = w_head_addr;
      mem_wdata = w_head_data;
    end
    disp_valid = disp_valid_q;
    wr_oob     = wr_oob_q;
    disp_data  = disp_valid_q ? mem_rdata : 3'b000;
  end

  // State register; reset aborts any clear and discards queued writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= c_st_idle;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      disp_valid_q <= 1'b0;
      wr_oob_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
      disp_valid_q <= disp_valid_d;
      wr_oob_q     <= wr_oob_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_addr_q  <= fifo_addr_d;
      fifo_data_q  <= fifo_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fb_arbiter
// Description : Self-checking bench for fb_arbiter on a reduced 200-pixel
//               frame with a behavioural RAM, a write log and a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

  localparam int FB_SIZE    = 200;
  localparam int ADDR_W     = 9;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [2:0]        disp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;
  logic              wr_oob;
  logic              clr_start;
  logic [2:0]        clr_color;
  logic              clr_busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_wdata;
  logic [2:0]        mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_arbiter #(
    .FB_SIZE    (FB_SIZE),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_oob     (wr_oob),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Behavioural single-port RAM with 1-cycle read latency; logs every write.
  logic [2:0] ram [0:(1<<ADDR_W)-1];
  int log_addr[$];
  int log_data[$];
  int oob_seen = 0;

  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      ram[mem_addr] <= mem_wdata;
      log_addr.push_back(int'(mem_addr));
      log_data.push_back(int'(mem_wdata));
    end
    if (mem_en === 1'b1 && mem_we === 1'b0) mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) if (wr_oob === 1'b1) oob_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_data = '0; clr_start = 1'b0; clr_color = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; disp_req = 1'b1; disp_addr = 9'd17; wr_valid = 1'b1;
    wr_addr = 9'd3; wr_data = 3'd6; clr_start = 1'b1; clr_color = 3'd5;
    #3;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
    checks++; if (mem_wdata !== 3'd0) begin errors++; $display("FAIL reset_mem_wdata: got %0d want 0", mem_wdata); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    @(negedge clk); @(negedge clk);
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b want 0", clr_busy); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b want 0", disp_valid); end
    checks++; if (disp_data !== 3'd0) begin errors++; $display("FAIL reset_disp_data: got %0d want 0", disp_data); end
    checks++; if (wr_oob !== 1'b0) begin errors++; $display("FAIL reset_wr_oob: got %b want 0", wr_oob); end
    idle_inputs();
    #2 rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready: got %b want 1", wr_ready); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL post_reset_clr_busy: got %b want 0", clr_busy); end
  endtask

  task automatic test_scanout();
    logic [2:0] pix [3];
    pix[0] = 3'd5; pix[1] = 3'd3; pix[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = pix[i];
      @(negedge clk);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL preload_ready[%0d]: got %b want 1", i, wr_ready); end
    end
    tick(); idle_inputs(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      logic exp_v;
      tick();
      disp_req = (i < 3); disp_addr = ADDR_W'(i);
      @(negedge clk);
      if (i < 3) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ADDR_W'(i)) begin
          errors++; $display("FAIL scan_mem[%0d]: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", i, mem_en, mem_we, mem_addr, i);
        end
      end
      exp_v = (i >= 1 && i <= 3);
      checks++; if (disp_valid !== exp_v) begin errors++; $display("FAIL scan_valid[%0d]: got %b want %b", i, disp_valid, exp_v); end
      checks++;
      if (exp_v && disp_data !== pix[i-1]) begin errors++; $display("FAIL scan_data[%0d]: got %0d want %0d", i, disp_data, pix[i-1]); end
      else if (!exp_v && disp_data !== 3'd0) begin errors++; $display("FAIL scan_data_idle[%0d]: got %0d want 0", i, disp_data); end
    end
    tick(); idle_inputs();
  endtask

  task automatic test_contention();
    int wa [6];
    int wd [6];
    int idx;
    int base;
    base = log_addr.size();
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      wa[k] = int'($urandom_range(FB_SIZE - 1));
      wd[k] = int'($urandom_range(7));
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      disp_req = 1'b1; disp_addr = ADDR_W'($urandom_range(FB_SIZE - 1));
      wr_valid = (idx < 6); wr_addr = ADDR_W'(wa[idx]); wr_data = 3'(wd[idx]);
      @(negedge clk);
      checks++; if (wr_ready !== (idx < FIFO_DEPTH)) begin errors++; $display("FAIL cont_ready[%0d]: got %b want %b", c, wr_ready, idx < FIFO_DEPTH); end
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== disp_addr) begin
        errors++; $display("FAIL cont_mem[%0d]: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", c, mem_en, mem_we, mem_addr, disp_addr);
      end
      if (wr_valid && wr_ready) idx++;
    end
    checks++; if (idx != FIFO_DEPTH) begin errors++; $display("FAIL cont_accepts: got %0d want %0d", idx, FIFO_DEPTH); end
    checks++; if (log_addr.size() != base) begin errors++; $display("FAIL cont_no_write: got %0d writes want 0", log_addr.size() - base); end
    for (int c = 0; c < 40 && (idx < 6 || log_addr.size() < base + 6); c++) begin
      tick();
      disp_req = 1'b0;
      wr_valid = (idx < 6);
      wr_addr = (idx < 6) ? ADDR_W'(wa[idx]) : '0;
      wr_data = (idx < 6) ? 3'(wd[idx]) : '0;
      @(negedge clk);
      if (wr_valid && wr_ready) idx++;
    end
    tick(); idle_inputs();
    checks++; if (log_addr.size() != base + 6) begin errors++; $display("FAIL cont_retired: got %0d want 6", log_addr.size() - base); end
    for (int k = 0; k < 6 && base + k < log_addr.size(); k++) begin
      checks++;
      if (log_addr[base+k] != wa[k] || log_data[base+k] != wd[k]) begin
        errors++; $display("FAIL cont_order[%0d]: got %0d/%0d want %0d/%0d", k, log_addr[base+k], log_data[base+k], wa[k], wd[k]);
      end
    end
  endtask

  task automatic test_oob();
    int va [4];
    int vd [4];
    int base;
    int oob0;
    va[0] = FB_SIZE - 1; vd[0] = 1;
    va[1] = FB_SIZE;     vd[1] = 7;
    va[2] = 511;         vd[2] = 4;
    va[3] = 0;           vd[3] = 6;
    base = log_addr.size();
    oob0 = oob_seen;
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_valid = 1'b1; wr_addr = ADDR_W'(va[i]); wr_data = 3'(vd[i]);
      @(negedge clk);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oob_ready[%0d]: got %b want 1", i, wr_ready); end
    end
    tick(); idle_inputs();
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    checks++; if (oob_seen - oob0 != 2) begin errors++; $display("FAIL oob_pulses: got %0d want 2", oob_seen - oob0); end
    checks++;
    if (log_addr.size() != base + 2) begin errors++; $display("FAIL oob_writes: got %0d want 2", log_addr.size() - base); end
    else if (log_addr[base] != FB_SIZE - 1 || log_data[base] != 1 || log_addr[base+1] != 0 || log_data[base+1] != 6) begin
      errors++; $display("FAIL oob_contents: got %0d/%0d %0d/%0d want %0d/1 0/6", log_addr[base], log_data[base], log_addr[base+1], log_data[base+1], FB_SIZE - 1);
    end
  endtask

  task automatic test_random();
    int ea[$];
    int ed[$];
    int occ;
    int exp_oob;
    int base;
    int oob0;
    logic prev_req;
    logic exp_ready;
    logic pop;
    occ = 0; exp_oob = 0; prev_req = 1'b0;
    base = log_addr.size();
    oob0 = oob_seen;
    for (int c = 0; c < 300; c++) begin
      tick();
      disp_req  = ($urandom_range(99) < 40);
      disp_addr = ADDR_W'($urandom_range(FB_SIZE - 1));
      wr_valid  = ($urandom_range(99) < 60);
      wr_addr   = ($urandom_range(3) == 0) ? ADDR_W'($urandom_range(511, FB_SIZE)) : ADDR_W'($urandom_range(FB_SIZE - 1));
      wr_data   = 3'($urandom_range(7));
      @(negedge clk);
      exp_ready = (occ < FIFO_DEPTH);
      checks++; if (wr_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, wr_ready, exp_ready); end
      checks++; if (disp_valid !== prev_req) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, disp_valid, prev_req); end
      if (disp_req) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== disp_addr) begin
          errors++; $display("FAIL rnd_read[%0d]: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", c, mem_en, mem_we, mem_addr, disp_addr);
        end
      end
      pop = !disp_req && occ > 0;
      if (wr_valid && exp_ready) begin
        occ++;
        if (int'(wr_addr) >= FB_SIZE) exp_oob++;
        else begin ea.push_back(int'(wr_addr)); ed.push_back(int'(wr_data)); end
      end
      if (pop) occ--;
      prev_req = disp_req;
    end
    tick(); idle_inputs();
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    checks++; if (oob_seen - oob0 != exp_oob) begin errors++; $display("FAIL rnd_oob: got %0d want %0d", oob_seen - oob0, exp_oob); end
    checks++; if (log_addr.size() - base != ea.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", log_addr.size() - base, ea.size()); end
    for (int k = 0; k < ea.size() && base + k < log_addr.size(); k++) begin
      checks++;
      if (log_addr[base+k] != ea[k] || log_data[base+k] != ed[k]) begin
        errors++; $display("FAIL rnd_order[%0d]: got %0d/%0d want %0d/%0d", k, log_addr[base+k], log_data[base+k], ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_clear();
    int ca [3];
    int cd [3];
    int base;
    int n;
    int prev_size;
    int bad;
    base = log_addr.size();
    for (int i = 0; i < 3; i++) begin
      ca[i] = int'($urandom_range(FB_SIZE - 1)); cd[i] = 5 + (i % 3);
      tick();
      disp_req = 1'b1; wr_valid = 1'b1; wr_addr = ADDR_W'(ca[i]); wr_data = 3'(cd[i]);
      @(negedge clk);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clr_queue_ready[%0d]: got %b want 1", i, wr_ready); end
    end
    tick();
    wr_valid = 1'b0; disp_req = 1'b1; clr_start = 1'b1; clr_color = 3'b010;
    tick();
    clr_start = 1'b0; clr_color = 3'b000; disp_req = 1'b0;
    @(negedge clk);
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise: got %b want 1", clr_busy); end
    n = 0;
    prev_size = log_addr.size();
    while (clr_busy === 1'b1 && n < 3000) begin
      prev_size = log_addr.size();
      tick();
      disp_req  = ($urandom_range(99) < 30);
      disp_addr = ADDR_W'($urandom_range(FB_SIZE - 1));
      clr_start = (n == 50);
      clr_color = (n == 50) ? 3'b111 : 3'b000;
      @(negedge clk);
      if (clr_busy === 1'b1) begin
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready[%0d]: got %b want 0", n, wr_ready); end
      end
      n++;
    end
    idle_inputs();
    checks++; if (n >= 3000) begin errors++; $display("FAIL clr_timeout: busy=%b after %0d cycles want 0", clr_busy, n); end
    checks++; if (prev_size != base + 2 + FB_SIZE) begin errors++; $display("FAIL clr_busy_fall: got %0d writes before fall want %0d", prev_size - base, 2 + FB_SIZE); end
    checks++; if (log_addr.size() != base + 3 + FB_SIZE) begin errors++; $display("FAIL clr_count: got %0d want %0d", log_addr.size() - base, 3 + FB_SIZE); end
    for (int k = 0; k < 3 && base + k < log_addr.size(); k++) begin
      checks++;
      if (log_addr[base+k] != ca[k] || log_data[base+k] != cd[k]) begin
        errors++; $display("FAIL clr_drain[%0d]: got %0d/%0d want %0d/%0d", k, log_addr[base+k], log_data[base+k], ca[k], cd[k]);
      end
    end
    bad = -1;
    for (int k = 0; k < FB_SIZE && base + 3 + k < log_addr.size(); k++)
      if (bad < 0 && (log_addr[base+3+k] != k || log_data[base+3+k] != 2)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL clr_sweep[%0d]: got %0d/%0d want %0d/2", bad, log_addr[base+3+bad], log_data[base+3+bad], bad);
    end
    tick();
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clr_after_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_reset_mid_clear();
    int base;
    int n;
    int bad;
    base = log_addr.size();
    tick();
    clr_start = 1'b1; clr_color = 3'b011;
    tick();
    clr_start = 1'b0; clr_color = 3'b000;
    n = 0;
    @(negedge clk);
    while (log_addr.size() < base + 100 && n < 500) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", clr_busy); end
    rst_n = 1'b0; disp_req = 1'b1; disp_addr = 9'd42;
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", clr_busy); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL mid_mem_en: got %b want 0", mem_en); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL mid_mem_addr: got %0d want 0", mem_addr); end
    @(posedge clk); #2;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL mid_disp_valid: got %b want 0", disp_valid); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    base = log_addr.size();
    tick();
    clr_start = 1'b1; clr_color = 3'b101;
    tick();
    clr_start = 1'b0; clr_color = 3'b000;
    n = 0;
    @(negedge clk);
    while (clr_busy === 1'b1 && n < 1000) begin
      tick();
      disp_req = ($urandom_range(99) < 20);
      @(negedge clk);
      n++;
    end
    idle_inputs();
    checks++; if (n >= 1000) begin errors++; $display("FAIL restart_timeout: busy=%b want 0", clr_busy); end
    checks++; if (log_addr.size() != base + FB_SIZE) begin errors++; $display("FAIL restart_count: got %0d want %0d", log_addr.size() - base, FB_SIZE); end
    bad = -1;
    for (int k = 0; k < FB_SIZE && base + k < log_addr.size(); k++)
      if (bad < 0 && (log_addr[base+k] != k || log_data[base+k] != 5)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL restart_sweep[%0d]: got %0d/%0d want %0d/5", bad, log_addr[base+bad], log_data[base+bad], bad);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_scanout();
    test_contention();
    test_oob();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FB_SIZE, default 307200, shall set the number of frame-buffer pixels (640x480).
REQ-002 Parameter ADDR_W, default 19, shall set the pixel address width.
REQ-003 Parameter FIFO_DEPTH, default 4, shall set the number of entries in the write queue (power of two).
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port disp_req, input, 1: the scanout requests a pixel read this cycle.
REQ-007 Port disp_addr, input, ADDR_W: the scanout read address.
REQ-008 Port disp_valid, output, 1: disp_data is valid this cycle.
REQ-009 Port disp_data, output, 3: the read pixel {r,g,b}.
REQ-010 Port wr_valid, input, 1: the writer offers a pixel write.
REQ-011 Port wr_ready, output, 1: the arbiter accepts the write this cycle.
REQ-012 Port wr_addr, input, ADDR_W: the write address.
REQ-013 Port wr_data, input, 3: the write pixel.
REQ-014 Port wr_oob, output, 1: one-cycle pulse when an accepted write's address is >= FB_SIZE.
REQ-015 Port clr_start, input, 1: a pulse that requests a full-frame clear.
REQ-016 Port clr_color, input, 3: the fill colour, sampled when clr_start is accepted.
REQ-017 Port clr_busy, output, 1: a clear is pending or in progress.
REQ-018 Port mem_en, output, 1: the RAM access enable.
REQ-019 Port mem_we, output, 1: the RAM write enable; it is valid only while mem_en=1.
REQ-020 Port mem_addr, output, ADDR_W: the RAM address.
REQ-021 Port mem_wdata, output, 3: the RAM write data.
REQ-022 Port mem_rdata, input, 3: the RAM read data, registered, with a latency of 1 cycle after mem_en with mem_we=0.

Function
REQ-023 The memory outputs (mem_en, mem_we, mem_addr, mem_wdata) shall be combinational from the current-cycle requests and state.
REQ-024 The RAM is single-ported, and the arbiter shall issue at most one access per cycle.
REQ-025 Priority shall be fixed: scanout read first, then clear write, then FIFO write.
REQ-026 If disp_req=1, the arbiter shall drive mem_en=1, mem_we=0 and mem_addr=disp_addr, whatever the state.
REQ-027 disp_valid shall equal disp_req delayed by exactly 1 cycle.
REQ-028 disp_data shall equal mem_rdata when disp_valid=1, and 3'b000 otherwise.
REQ-029 A write is accepted on a cycle where wr_valid=1 and wr_ready=1, and shall be pushed into the FIFO.
REQ-030 wr_ready shall be 1 when the FIFO is not full and clr_busy=0.
REQ-031 The FIFO shall pop on a cycle where disp_req=0, the state is not CLEAR, and the FIFO is non-empty.
REQ-032 On a pop with addr < FB_SIZE, the arbiter shall drive mem_en=1, mem_we=1, mem_addr=addr and mem_wdata=data.
REQ-033 On a pop with addr >= FB_SIZE, the entry shall be discarded: mem_en=0 that cycle, and wr_oob=1 on the next cycle.
REQ-034 A push and a pop in the same cycle shall both take effect, leaving the occupancy unchanged.
REQ-035 A push is impossible when the FIFO is full, because wr_ready=0.
REQ-036 Writes shall retire in acceptance order.
REQ-037 The state machine shall have three states: IDLE, DRAIN and CLEAR.
REQ-038 IDLE -> DRAIN on clr_start=1, latching clr_color.
REQ-039 DRAIN -> CLEAR when the FIFO is empty; the clear counter is set to 0 on entry.
REQ-040 IDLE -> CLEAR directly on clr_start=1 if the FIFO is already empty.
REQ-041 In CLEAR, on each cycle with disp_req=0, the arbiter shall write the latched colour at the counter address and then increment the counter.
REQ-042 In CLEAR, a cycle with disp_req=1 shall stall the counter.
REQ-043 After the write to address FB_SIZE-1, the state shall go CLEAR -> IDLE on the next edge.
REQ-044 clr_start received in DRAIN or CLEAR shall be ignored, and the latched colour shall not change.
REQ-045 clr_busy shall be 1 exactly while the state is DRAIN or CLEAR.
REQ-046 The clear counter is ADDR_W bits wide and shall never exceed FB_SIZE-1.
REQ-047 When no requester is active, the arbiter shall drive mem_en=0 and mem_we=0.

Reset
REQ-048 While rst_n=0, asynchronously: state=IDLE, FIFO empty, clear counter=0, latched colour=0, and the registered outputs disp_valid=0 and wr_oob=0.
REQ-049 While rst_n=0, the combinational outputs shall settle to: disp_data=0, wr_ready=0, clr_busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-050 A reset during CLEAR shall abort the clear; the RAM contents are then undefined by this block.
REQ-051 A reset shall discard any FIFO entries that have not been written.
REQ-052 Outputs take their normal values from the first clock edge after rst_n rises.

Verification
REQ-053 Scanout only: disp_req=1 with addr 0,1,2 on consecutive cycles, RAM preloaded with 5,3,7 -> disp_valid high on cycles 1-3, disp_data=5,3,7.
REQ-054 Contention: wr_valid held with 6 writes while disp_req=1 for 10 cycles -> wr_ready drops after 4 accepts, no mem_we=1 during those 10 cycles, then 6 writes retire in order.
REQ-055 Out of range: write to addr 307200 with data 7 -> accepted, wr_oob pulses once, no RAM write.
REQ-056 Clear with pending writes: 3 writes queued, then clr_start with clr_color=3'b010 -> DRAIN writes the 3 queued writes first, then 307200 writes of 2, then clr_busy falls; disp_req bursts stall the counter with no address skipped or repeated.
REQ-057 A second clr_start with clr_color=3'b111 during CLEAR -> ignored; every address is still written with 2.
REQ-058 rst_n asserted mid-CLEAR at counter 1000 -> clr_busy=0 and mem_en=0 immediately; the next clr_start restarts the clear at address 0.
